spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
//   Shares one spi_master between NUM_REQ requesters with round-robin arbitration.
//   Sequences each transfer: grant, start pulse, wait for completion, return rx word, inter-frame gap.
//   Sits between client logic and the spi_master/spi_slave datapath.
//   Adds a per-transfer timeout so a stuck master cannot hang the bus.
// PARAMETERS
//   NUM_REQ     2   number of requesters (2..8)
//   DATA_WIDTH  12  SPI word width in bits
//   GAP_CYCLES  4   idle clk cycles forced between transfers (0 = none)
//   TIMEOUT     256 max clk cycles in WAIT before abort (>=2)
// PORTS
//   clk         in   1                   system clock, all logic on posedge
//   rst         in   1                   asynchronous reset, active-high
//   req         in   NUM_REQ             per-requester level request, hold until done[i]
//   tx_data     in   NUM_REQ*DATA_WIDTH  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         out  NUM_REQ             one-hot grant, high while transfer owned
//   done        out  NUM_REQ             1-cycle completion pulse to the owner
//   err         out  NUM_REQ             1-cycle timeout pulse, coincident with done
//   rx_data     out  DATA_WIDTH          word returned by last transfer, held until next
//   busy        out  1                   high in any state except IDLE
//   m_start     out  1                   1-cycle start pulse to spi_master
//   m_tx_data   out  DATA_WIDTH          word for spi_master, stable from m_start to m_done
//   m_done      in   1                   1-cycle completion pulse from spi_master
//   m_rx_data   in   DATA_WIDTH          received word, valid when m_done=1
// BEHAVIOUR
//   Reset (async): state=IDLE; gnt, done, err, rx_data, m_tx_data, m_start, busy all 0;
//     round-robin pointer = NUM_REQ-1, so requester 0 wins first after reset.
//   FSM states: IDLE, WAIT, GAP. All outputs registered.
//   IDLE: on posedge with |req: winner = first set req[] searching from pointer+1 (wrap mod NUM_REQ);
//     next cycle: gnt[winner]=1, m_tx_data=tx_data[winner], m_start=1 (exactly 1 cycle), pointer=winner,
//     state=WAIT. Latency req->m_start = 1 cycle. No req: stay IDLE.
//   WAIT: m_start=0; tx_data inputs ignored (word latched at grant); timeout counter increments per cycle.
//     m_done=1: next cycle rx_data=m_rx_data, done[winner]=1, gnt cleared, state=GAP.
//     counter reaches TIMEOUT-1 with no m_done: next cycle done[winner]=1, err[winner]=1,
//       rx_data unchanged, gnt cleared, state=GAP.
//     m_done and timeout in same cycle: m_done wins, no err.
//   GAP: counts GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0: go straight to IDLE (state still entered
//     for the done cycle). Requests ignored during GAP; m_done during GAP/IDLE ignored.
//   Back-to-back: next m_start no earlier than GAP_CYCLES+2 cycles after the done pulse cycle.
//   Requester drops req mid-transfer: transfer completes normally, done still pulsed.
//   Only the winner sees done/err; all other bits stay 0. gnt, done, err are always one-hot or zero.
//   Round-robin: a continuously requesting client waits at most NUM_REQ-1 transfers.
//   Reset mid-transfer: immediate return to reset values, pending transfer dropped, no done pulse.
//   Counters sized $clog2(TIMEOUT+1) and $clog2(GAP_CYCLES+1); no overflow paths.
// TESTING
//   1 Reset: assert rst mid-clock -> all outputs 0 immediately without clk edge, busy=0.
//   2 Single: req[0]=1, tx0=12'h82A -> m_start 1 cycle later, m_tx_data=12'h82A, gnt=2'b01;
//     m_done with m_rx_data=12'h5A5 -> next cycle done=2'b01, rx_data=12'h5A5, err=0.
//   3 Contention: req=2'b11 held, slave answers each in 20 clks -> grant order 0,1,0,1; each
//     m_start spaced >= GAP_CYCLES+2 cycles after the previous done.
//   4 Timeout: TIMEOUT=16, req[1]=1, m_done never -> done=2'b10 and err=2'b10 on the 17th cycle
//     after m_start; rx_data unchanged; next request served normally.
//   5 Reset mid-WAIT: rst pulse 5 cycles after m_start -> no done, gnt=0; req[0]&req[1] after
//     release -> requester 0 granted first.
//   6 Edge: req[0] dropped during WAIT -> done[0] still pulses; m_done in IDLE -> no output change.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master between NUM_REQ clients.
// Each transfer is sequenced as grant + start pulse, wait for completion
// (bounded by a timeout), return of the rx word, then a forced idle gap.
module spi_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          busy,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  input  logic                          m_done,
  input  logic [DATA_WIDTH-1:0]         m_rx_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [TW-1:0]         r_tcnt;
  logic [GW-1:0]         r_gcnt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_done;
  logic [NUM_REQ-1:0]    r_err;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_busy;
  logic                  r_m_start;
  logic [DATA_WIDTH-1:0] r_m_tx_data;

  logic [PW-1:0]         w_win;
  logic [NUM_REQ-1:0]    w_win_oh;
  logic [DATA_WIDTH-1:0] w_win_word;
  int unsigned           w_idx;

  // Round-robin pick: scan downward so the nearest set request after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_idx = r_ptr + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req[w_idx]) w_win = PW'(w_idx);
    end
  end

  // Decode the winner into a one-hot grant and select its tx word.
  always_comb begin
    w_win_oh   = '0;
    w_win_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == PW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_win_word  = tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer sequencer: IDLE -> WAIT -> GAP -> IDLE, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NUM_REQ - 1);
      r_tcnt      <= '0;
      r_gcnt      <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rx_data   <= '0;
      r_busy      <= 1'b0;
      r_m_start   <= 1'b0;
      r_m_tx_data <= '0;
    end else begin
      r_m_start <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt       <= w_win_oh;
            r_m_tx_data <= w_win_word;
            r_m_start   <= 1'b1;
            r_ptr       <= w_win;
            r_tcnt      <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The counter holds during the start-pulse cycle, so the abort
          // lands TIMEOUT+1 cycles after m_start is seen.
          if (m_done) begin
            r_rx_data <= m_rx_data;
            r_done    <= r_gnt;
            r_gnt     <= '0;
            r_gcnt    <= '0;
            r_state   <= S_GAP;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_done    <= r_gnt;
            r_err     <= r_gnt;
            r_gnt     <= '0;
            r_gcnt    <= '0;
            r_state   <= S_GAP;
          end else if (!r_m_start) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP_CYCLES)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rx_data   = r_rx_data;
  assign busy      = r_busy;
  assign m_start   = r_m_start;
  assign m_tx_data = r_m_tx_data;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: one instance with default timing, one with
// TIMEOUT=16 for the abort path. Inputs driven and outputs sampled on negedge.
module tb_spi_arbiter;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_t = '0;
  logic [23:0] tx_data = '0;
  logic        m_done = 1'b0;
  logic        m_done_t = 1'b0;
  logic [11:0] m_rx = '0;
  logic [11:0] m_rx_t = '0;

  logic [1:0]  gnt, done, err, gnt_t, done_t, err_t;
  logic [11:0] rx_data, m_tx, rx_t, m_tx_t;
  logic        busy, m_start, busy_t, m_start_t;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int st = 0;
  int last_done = 0;
  logic [1:0]  exp_g;
  logic [11:0] exp_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_arbiter #(.NUM_REQ(2), .DATA_WIDTH(12), .GAP_CYCLES(GAP), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_data(tx_data),
    .gnt(gnt), .done(done), .err(err), .rx_data(rx_data), .busy(busy),
    .m_start(m_start), .m_tx_data(m_tx), .m_done(m_done), .m_rx_data(m_rx)
  );

  spi_arbiter #(.NUM_REQ(2), .DATA_WIDTH(12), .GAP_CYCLES(GAP), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .req(req_t), .tx_data(tx_data),
    .gnt(gnt_t), .done(done_t), .err(err_t), .rx_data(rx_t), .busy(busy_t),
    .m_start(m_start_t), .m_tx_data(m_tx_t), .m_done(m_done_t), .m_rx_data(m_rx_t)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Advance to the negedge where the selected instance shows m_start.
  task automatic wait_start(input bit t, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (!(t ? m_start_t : m_start) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(t ? m_start_t : m_start), 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle(input bit t);
    int n;
    n = 0;
    while ((t ? busy_t : busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_seen", 32'(t ? busy_t : busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);

    // 1: async reset clears a live grant without a clock edge
    rst = 1'b0;
    @(negedge clk);
    req = 2'b01;
    tx_data[11:0] = 12'h123;
    @(negedge clk);
    chk("t1_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_gnt", 32'(gnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_mstart", 32'(m_start), 32'd0);
    chk("t1_mtx", 32'(m_tx), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_rx", 32'(rx_data), 32'd0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // 2: single transfer from requester 0
    @(negedge clk);
    req = 2'b01;
    tx_data[11:0] = 12'h82A;
    @(negedge clk);
    chk("t2_mstart", 32'(m_start), 32'd1);
    chk("t2_mtx", 32'(m_tx), 32'h82A);
    chk("t2_gnt", 32'(gnt), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    tx_data[11:0] = 12'hFFF;
    @(negedge clk);
    chk("t2_mstart_pulse", 32'(m_start), 32'd0);
    @(negedge clk);
    chk("t2_mtx_stable", 32'(m_tx), 32'h82A);
    m_done = 1'b1;
    m_rx = 12'h5A5;
    @(negedge clk);
    m_done = 1'b0;
    m_rx = 12'h000;
    req = 2'b00;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_rx", 32'(rx_data), 32'h5A5);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_gnt_clr", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_busy_gap", 32'(busy), 32'd1);

    // 5: reset 5 cycles into WAIT drops the transfer and rewinds the pointer
    wait_idle(1'b0);
    req = 2'b01;
    @(negedge clk);
    chk("t5_mstart", 32'(m_start), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("t5_done_held", 32'(done), 32'd0);
    rst = 1'b0;
    req = 2'b11;
    tx_data = {12'h0B2, 12'h0A1};

    // 3: contention, slave answers in 20 clocks, grant order 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      wait_start(1'b0, st);
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
      exp_w = (t % 2 == 1) ? 12'h0B2 : 12'h0A1;
      chk("t3_gnt", 32'(gnt), 32'(exp_g));
      chk("t3_mtx", 32'(m_tx), 32'(exp_w));
      if (t > 0) chk("t3_gap", 32'(st - last_done >= GAP + 2), 32'd1);
      repeat (19) @(negedge clk);
      m_done = 1'b1;
      m_rx = 12'h100 + 12'(t);
      @(negedge clk);
      m_done = 1'b0;
      chk("t3_done", 32'(done), 32'(exp_g));
      chk("t3_rx", 32'(rx_data), 32'h100 + 32'(t));
      chk("t3_err", 32'(err), 32'd0);
      last_done = cyc;
      if (t == 3) req = 2'b00;
    end

    // 6: requester drops req mid-WAIT; m_done while idle is ignored
    wait_idle(1'b0);
    req = 2'b01;
    tx_data[11:0] = 12'h1E1;
    wait_start(1'b0, st);
    chk("t6_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    m_done = 1'b1;
    m_rx = 12'h6C6;
    @(negedge clk);
    m_done = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_rx", 32'(rx_data), 32'h6C6);
    wait_idle(1'b0);
    @(negedge clk);
    m_done = 1'b1;
    m_rx = 12'hABC;
    @(negedge clk);
    m_done = 1'b0;
    chk("t6_idle_rx", 32'(rx_data), 32'h6C6);
    chk("t6_idle_done", 32'(done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_gnt", 32'(gnt), 32'd0);
    chk("t6_idle_mstart", 32'(m_start), 32'd0);

    // 4: timeout on the TIMEOUT=16 instance
    tx_data[23:12] = 12'h3C3;
    req_t = 2'b10;
    wait_start(1'b1, st);
    chk("t4_pre_gnt", 32'(gnt_t), 32'd2);
    chk("t4_pre_mtx", 32'(m_tx_t), 32'h3C3);
    @(negedge clk);
    m_done_t = 1'b1;
    m_rx_t = 12'h777;
    @(negedge clk);
    m_done_t = 1'b0;
    req_t = 2'b00;
    chk("t4_pre_done", 32'(done_t), 32'd2);
    chk("t4_pre_rx", 32'(rx_t), 32'h777);
    wait_idle(1'b1);
    req_t = 2'b10;
    wait_start(1'b1, st);
    chk("t4_gnt", 32'(gnt_t), 32'd2);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) chk("t4_no_early_done", 32'(done_t), 32'd0);
      if (k == 17) begin
        chk("t4_done", 32'(done_t), 32'd2);
        chk("t4_err", 32'(err_t), 32'd2);
        chk("t4_rx_kept", 32'(rx_t), 32'h777);
        chk("t4_gnt_clr", 32'(gnt_t), 32'd0);
        req_t = 2'b00;
      end
    end
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_t), 32'd0);
    wait_idle(1'b1);
    req_t = 2'b01;
    tx_data[11:0] = 12'h0D4;
    wait_start(1'b1, st);
    chk("t4_next_gnt", 32'(gnt_t), 32'd1);
    chk("t4_next_mtx", 32'(m_tx_t), 32'h0D4);
    @(negedge clk);
    m_done_t = 1'b1;
    m_rx_t = 12'h2E2;
    @(negedge clk);
    m_done_t = 1'b0;
    req_t = 2'b00;
    chk("t4_next_done", 32'(done_t), 32'd1);
    chk("t4_next_err", 32'(err_t), 32'd0);
    chk("t4_next_rx", 32'(rx_t), 32'h2E2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
